boot_copier: RTL and testbench
==============================

Name: boot_copier

Overview:
Parametrised successor to the flash-to-SRAM boot deliverer. After a boot request it copies a run-time length of words from a flash region to an SRAM region through the flash/SRAM controller request/done channels. It can optionally read back each word and compare it, keeps a running checksum, and enforces a per-access timeout. It sits between the top-level memory wrapper's boot logic and the flash/SRAM interface controller, and it releases the CPU through `start` when the copy completes.

Parameters:
FLASH_AW, 25, flash word-address width
SRAM_AW, 22, SRAM word-address width
DW, 32, data width of both channels
LENW, 16, width of copy_len and word counters
FLASH_BASE, 0, first flash word address copied
SRAM_BASE, 0, first SRAM word address written
VERIFY, 1, 1 = read back and compare every SRAM write; 0 = skip readback
TIMEOUT, 1023, max cycles a cs may stay high without done; must be ≥1

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst_in  input  1  asynchronous, active-high reset
boot  input  1  copy request; its rising edge starts a copy
copy_len  input  LENW  number of words to copy; latched on the start edge
flash_cs  output  1  flash read request, held until flash_done
flash_addr  output  FLASH_AW  flash word address
flash_data_rd  input  DW  flash read data, valid in the flash_done cycle
flash_done  input  1  one-cycle completion pulse from the flash controller
sram_cs  output  1  SRAM request, held until sram_done
sram_rw  output  1  1 = write, 0 = read
sram_addr  output  SRAM_AW  SRAM word address
sram_data_wr  output  DW  SRAM write data
sram_data_rd  input  DW  SRAM read data, valid in the sram_done cycle
sram_done  input  1  one-cycle completion pulse from the SRAM controller
busy  output  1  copy in progress
start  output  1  copy finished successfully; CPU may run
error  output  1  copy aborted
err_code  output  2  01 = verify mismatch, 10 = flash timeout, 11 = SRAM timeout
err_idx  output  LENW  word index at which the error occurred
checksum  output  DW  sum modulo 2^DW of all words read from flash
words_done  output  LENW  count of words completed

Behaviour:
Reset:
- rst_in high forces state IDLE immediately, regardless of clock.
- All outputs are 0; addresses and data are 0; the boot edge detector is cleared.
- Reset mid-transfer drops cs in the same instant. Any late done from the controller is ignored afterwards.

Start:
- A boot rising edge (boot=1 now, 0 the previous cycle) is accepted only in IDLE, DONE or FAIL.
- On acceptance: latch copy_len; clear idx, checksum, words_done, error, err_code, err_idx and start; set busy.
- Edges during busy are ignored.
- copy_len=0: go directly to DONE on the next cycle with checksum=0.

States:
- IDLE
- FRD: flash_cs=1, flash_addr=(FLASH_BASE+idx) mod 2^FLASH_AW. On flash_done: latch data into a word register, checksum += data, go to SWR.
- SWR: sram_cs=1, sram_rw=1, sram_addr=(SRAM_BASE+idx) mod 2^SRAM_AW, sram_data_wr=word. On sram_done: go to SVR if VERIFY=1, else NXT.
- SVR: sram_cs=1, sram_rw=0, same address. On sram_done: if sram_data_rd≠word go to FAIL with code 01, else go to NXT.
- NXT (one cycle): idx++, words_done++. If idx+1==len go to DONE, else go to FRD.
- DONE: busy=0, start=1. Hold until reset or a new boot edge.
- FAIL: busy=0, error=1, err_idx=idx. Hold until reset or a new boot edge.

Handshake:
- cs rises on entry to an access state.
- cs falls in the cycle after done is sampled.
- A done arriving while the matching cs is low is ignored.
- Any two accesses are separated by at least one cs-low cycle.

Timeout:
- A counter clears on entry to each access state and increments every cycle cs is high.
- When it reaches TIMEOUT without done: go to FAIL with code 10 (FRD) or 11 (SWR/SVR). cs drops the next cycle.
- If done arrives in the same cycle the counter reaches TIMEOUT, done wins.

Addresses:
- Address arithmetic wraps silently at the address width; there is no error on wrap.

Test Plan:
- copy_len=4, flash words 0x11111111..0x44444444, VERIFY=1, controller done latency 3 → SRAM holds the 4 words; checksum=0xAAAAAAAA; start=1; words_done=4; cs low 1 cycle between accesses.
- copy_len=0, boot edge → no cs ever asserted; start=1 two cycles after the edge; checksum=0.
- SRAM model returns bit 0 flipped on readback of idx 2 → error=1, err_code=01, err_idx=2, words_done=2, start=0.
- Flash model never sends done, TIMEOUT=15 → FAIL 16 cycles after flash_cs rises, err_code=10; flash_cs=0 afterwards.
- FLASH_BASE=2^25−2, copy_len=4 → flash addresses 0x1FFFFFE, 0x1FFFFFF, 0x0, 0x1.
- Assert rst_in during SWR of idx 1, then release and boot again with copy_len=2 → all outputs 0 during reset; the second copy completes cleanly from idx 0; a late sram_done injected after reset is ignored.

Source files
------------

// File: rtl/boot_copier.sv
// Boot-time copier: moves copy_len words from flash to SRAM over the controller
// request/done channels, with optional readback verify, checksum and access timeout.
//
// state | meaning
// IDLE  | waiting for a boot edge
// LOAD  | length latched; empty copy goes straight to DONE
// FRD   | flash read of word idx
// SWR   | SRAM write of word idx
// SVR   | SRAM readback of word idx and compare
// NXT   | advance idx / words_done
// DONE  | copy complete, start held high
// FAIL  | copy aborted, error and err_code/err_idx held
module boot_copier #(
   parameter int                  FLASH_AW   = 25,
   parameter int                  SRAM_AW    = 22,
   parameter int                  DW         = 32,
   parameter int                  LENW       = 16,
   parameter logic [FLASH_AW-1:0] FLASH_BASE = '0,
   parameter logic [SRAM_AW-1:0]  SRAM_BASE  = '0,
   parameter bit                  VERIFY     = 1'b1,
   parameter int                  TIMEOUT    = 1023
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                boot,
   input  logic [LENW-1:0]     copy_len,
   output logic                flash_cs,
   output logic [FLASH_AW-1:0] flash_addr,
   input  logic [DW-1:0]       flash_data_rd,
   input  logic                flash_done,
   output logic                sram_cs,
   output logic                sram_rw,
   output logic [SRAM_AW-1:0]  sram_addr,
   output logic [DW-1:0]       sram_data_wr,
   input  logic [DW-1:0]       sram_data_rd,
   input  logic                sram_done,
   output logic                busy,
   output logic                start,
   output logic                error,
   output logic [1:0]          err_code,
   output logic [LENW-1:0]     err_idx,
   output logic [DW-1:0]       checksum,
   output logic [LENW-1:0]     words_done
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FRD, S_SWR, S_SVR, S_NXT, S_DONE, S_FAIL
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_boot_q;
   logic [LENW-1:0] r_len;
   logic [LENW-1:0] r_idx;
   logic [DW-1:0]   r_word;
   logic [DW-1:0]   r_checksum;
   logic [LENW-1:0] r_words_done;
   logic [1:0]      r_err_code;
   logic [LENW-1:0] r_err_idx;
   logic            r_ack;
   logic [TW-1:0]   r_tmo;

   logic w_boot_edge;
   logic w_accept;
   logic w_cs_flash;
   logic w_cs_sram;
   logic w_cs;
   logic w_done;
   logic w_tmo;
   logic w_mismatch;
   logic w_last;

   // r_ack marks the cycle after done: cs is already low, the state advances at its end
   assign w_boot_edge = boot && !r_boot_q;
   assign w_accept    = w_boot_edge &&
                        (r_state == S_IDLE || r_state == S_DONE || r_state == S_FAIL);
   assign w_cs_flash  = (r_state == S_FRD) && !r_ack;
   assign w_cs_sram   = (r_state == S_SWR || r_state == S_SVR) && !r_ack;
   assign w_cs        = w_cs_flash || w_cs_sram;
   assign w_done      = (w_cs_flash && flash_done) || (w_cs_sram && sram_done);
   assign w_tmo       = w_cs && !w_done && (r_tmo == '0);
   assign w_mismatch  = (r_state == S_SVR) && w_done && (sram_data_rd != r_word);
   assign w_last      = ((LENW+1)'(r_idx) + (LENW+1)'(1)) == (LENW+1)'(r_len);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_FAIL: if (w_accept) w_next = S_LOAD;
         S_LOAD: w_next = (r_len == '0) ? S_DONE : S_FRD;
         S_FRD: begin
            if (r_ack)      w_next = S_SWR;
            else if (w_tmo) w_next = S_FAIL;
         end
         S_SWR: begin
            if (r_ack)      w_next = VERIFY ? S_SVR : S_NXT;
            else if (w_tmo) w_next = S_FAIL;
         end
         S_SVR: begin
            if (w_mismatch) w_next = S_FAIL;
            else if (r_ack) w_next = S_NXT;
            else if (w_tmo) w_next = S_FAIL;
         end
         S_NXT:   w_next = w_last ? S_DONE : S_FRD;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      flash_cs     = w_cs_flash;
      flash_addr   = '0;
      sram_cs      = w_cs_sram;
      sram_rw      = 1'b0;
      sram_addr    = '0;
      sram_data_wr = '0;
      start        = 1'b0;
      error        = 1'b0;
      case (r_state)
         S_FRD: flash_addr = FLASH_BASE + FLASH_AW'(r_idx);
         S_SWR: begin
            sram_rw      = 1'b1;
            sram_addr    = SRAM_BASE + SRAM_AW'(r_idx);
            sram_data_wr = r_word;
         end
         S_SVR:   sram_addr = SRAM_BASE + SRAM_AW'(r_idx);
         S_DONE:  start = 1'b1;
         S_FAIL:  error = 1'b1;
         default: ;
      endcase
      busy = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_FAIL);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_boot_q     <= 1'b0;
         r_len        <= '0;
         r_idx        <= '0;
         r_word       <= '0;
         r_checksum   <= '0;
         r_words_done <= '0;
         r_err_code   <= '0;
         r_err_idx    <= '0;
         r_ack        <= 1'b0;
         r_tmo        <= TW'(TIMEOUT);
      end else begin
         r_boot_q <= boot;
         r_ack    <= w_done && !w_mismatch;
         // down-counter reloads whenever cs is low or the access completes
         r_tmo    <= (w_cs && !w_done) ? r_tmo - TW'(1) : TW'(TIMEOUT);
         if (w_accept) begin
            r_len        <= copy_len;
            r_idx        <= '0;
            r_checksum   <= '0;
            r_words_done <= '0;
            r_err_code   <= '0;
            r_err_idx    <= '0;
         end
         if (w_cs_flash && flash_done) begin
            r_word     <= flash_data_rd;
            r_checksum <= r_checksum + flash_data_rd;
         end
         if (r_state == S_NXT) begin
            r_idx        <= r_idx + LENW'(1);
            r_words_done <= r_words_done + LENW'(1);
         end
         if (w_mismatch) begin
            r_err_code <= 2'b01;
            r_err_idx  <= r_idx;
         end else if (w_tmo) begin
            r_err_code <= w_cs_flash ? 2'b10 : 2'b11;
            r_err_idx  <= r_idx;
         end
      end
   end

   assign err_code   = r_err_code;
   assign err_idx    = r_err_idx;
   assign checksum   = r_checksum;
   assign words_done = r_words_done;

endmodule

// File: tb/tb_boot_copier.sv
// Directed bench for boot_copier: behavioural flash/SRAM controllers with
// 3-cycle done latency, a cs monitor, and hand-computed expectations.
module tb_boot_copier;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        boot;
   logic [15:0] copy_len;
   logic        flash_cs;
   logic [24:0] flash_addr;
   logic [31:0] flash_data_rd;
   logic        flash_done;
   logic        sram_cs;
   logic        sram_rw;
   logic [21:0] sram_addr;
   logic [31:0] sram_data_wr;
   logic [31:0] sram_data_rd;
   logic        sram_done;
   logic        busy;
   logic        start;
   logic        error;
   logic [1:0]  err_code;
   logic [15:0] err_idx;
   logic [31:0] checksum;
   logic [15:0] words_done;

   int n_tests = 0;
   int n_fail  = 0;

   bit          f_hang      = 1'b0;
   bit          s_flip_en   = 1'b0;
   logic [21:0] s_flip_addr = 22'h000012;
   int          s_req       = 0;
   int          s_ack       = 0;

   logic [31:0] smem [0:63];
   logic [24:0] flog [0:63];
   int          nf        = 0;
   int          n_rise    = 0;
   int          n_gapviol = 0;

   boot_copier #(
      .FLASH_BASE (25'h1FFFFFE),
      .SRAM_BASE  (22'h000010),
      .VERIFY     (1'b1),
      .TIMEOUT    (15)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .boot          (boot),
      .copy_len      (copy_len),
      .flash_cs      (flash_cs),
      .flash_addr    (flash_addr),
      .flash_data_rd (flash_data_rd),
      .flash_done    (flash_done),
      .sram_cs       (sram_cs),
      .sram_rw       (sram_rw),
      .sram_addr     (sram_addr),
      .sram_data_wr  (sram_data_wr),
      .sram_data_rd  (sram_data_rd),
      .sram_done     (sram_done),
      .busy          (busy),
      .start         (start),
      .error         (error),
      .err_code      (err_code),
      .err_idx       (err_idx),
      .checksum      (checksum),
      .words_done    (words_done)
   );

   always #5 clk_in = ~clk_in;

   // flash word at offset k from FLASH_BASE holds (k+1)*0x11111111
   initial begin : flash_ctrl
      int          cnt;
      logic [24:0] off;
      cnt = 0;
      flash_done = 1'b0;
      flash_data_rd = '0;
      forever begin
         @(posedge clk_in); #1;
         flash_done = 1'b0;
         if (flash_cs && !f_hang) begin
            cnt++;
            if (cnt == 3) begin
               off = flash_addr - 25'h1FFFFFE;
               flash_data_rd = 32'h11111111 * (32'(off) + 32'd1);
               flash_done = 1'b1;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin : sram_ctrl
      int cnt;
      cnt = 0;
      sram_done = 1'b0;
      sram_data_rd = '0;
      forever begin
         @(posedge clk_in); #1;
         sram_done = 1'b0;
         if (s_req != s_ack) begin
            sram_done = 1'b1;
            s_ack = s_req;
         end else if (sram_cs) begin
            cnt++;
            if (cnt == 3) begin
               if (sram_rw) smem[sram_addr[5:0]] = sram_data_wr;
               else sram_data_rd = smem[sram_addr[5:0]] ^
                       ((s_flip_en && sram_addr == s_flip_addr) ? 32'h1 : 32'h0);
               sram_done = 1'b1;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin : cs_monitor
      logic pf;
      logic ps;
      pf = 1'b0;
      ps = 1'b0;
      forever begin
         @(posedge clk_in); #1;
         if (flash_cs && !pf) begin
            if (nf < 64) flog[nf] = flash_addr;
            nf++;
         end
         if ((flash_cs && !pf) || (sram_cs && !ps)) begin
            n_rise++;
            if (pf || ps) n_gapviol++;
         end
         pf = flash_cs;
         ps = sram_cs;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in); #2;
   endtask

   task automatic do_boot(input logic [15:0] len);
      copy_len = len;
      boot = 1'b1;
      step();
      boot = 1'b0;
   endtask

   task automatic wait_end(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (start || error) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   initial begin : main
      bit ok;
      int n;
      int nf0;
      int rise0;

      rst_in = 1'b0;
      boot = 1'b0;
      copy_len = '0;
      #1 rst_in = 1'b1;
      step(); step();
      chk("rst_ctrl", {busy, start, error, flash_cs, sram_cs, sram_rw}, 0);
      chk("rst_addr", {flash_addr, sram_addr, sram_data_wr}, 0);
      chk("rst_stat", {err_code, err_idx, checksum, words_done}, 0);
      rst_in = 1'b0;
      step();
      chk("idle_busy", busy, 0);

      // four-word copy with verify
      do_boot(16'd4);
      chk("c4_busy", busy, 1);
      wait_end(500, ok);
      chk("c4_end", ok, 1);
      chk("c4_start", {start, error, busy}, 3'b100);
      chk("c4_checksum", checksum, 32'hAAAAAAAA);
      chk("c4_words", words_done, 16'd4);
      chk("c4_sram0", smem[16], 32'h11111111);
      chk("c4_sram1", smem[17], 32'h22222222);
      chk("c4_sram2", smem[18], 32'h33333333);
      chk("c4_sram3", smem[19], 32'h44444444);
      chk("c4_nflash", nf, 4);
      chk("c4_faddr0", flog[0], 25'h1FFFFFE);
      chk("c4_faddr1", flog[1], 25'h1FFFFFF);
      chk("c4_faddr2", flog[2], 25'h0000000);
      chk("c4_faddr3", flog[3], 25'h0000001);
      chk("c4_rises", n_rise, 12);

      // empty copy
      rise0 = n_rise;
      step();
      do_boot(16'd0);
      chk("c0_e1", {busy, start}, 2'b10);
      step();
      chk("c0_e2", {busy, start, error}, 3'b010);
      chk("c0_checksum", checksum, 32'h0);
      chk("c0_words", words_done, 16'd0);
      step();
      chk("c0_no_cs", n_rise - rise0, 0);

      // readback of idx 2 returns bit 0 flipped
      s_flip_en = 1'b1;
      do_boot(16'd4);
      wait_end(500, ok);
      chk("vf_end", ok, 1);
      chk("vf_flags", {start, error, busy}, 3'b010);
      chk("vf_code", err_code, 2'b01);
      chk("vf_idx", err_idx, 16'd2);
      chk("vf_words", words_done, 16'd2);
      chk("vf_checksum", checksum, 32'h66666666);
      s_flip_en = 1'b0;

      // flash never answers
      f_hang = 1'b1;
      do_boot(16'd4);
      n = 0;
      while (!flash_cs && n < 100) begin
         step();
         n++;
      end
      chk("to_cs_seen", flash_cs, 1);
      n = 0;
      while (!error && n < 100) begin
         step();
         n++;
      end
      chk("to_latency", n, 16);
      chk("to_code", err_code, 2'b10);
      chk("to_flags", {flash_cs, start, busy}, 3'b000);
      chk("to_idx", {err_idx, words_done}, 32'h0);
      step();
      chk("to_cs_low", flash_cs, 0);
      f_hang = 1'b0;

      // reset during the SRAM write of idx 1
      do_boot(16'd4);
      n = 0;
      while (!(sram_cs && sram_rw && sram_addr == 22'h000011) && n < 200) begin
         step();
         n++;
      end
      chk("rs_found", sram_cs, 1);
      rst_in = 1'b1;
      #1;
      chk("rs_cs", {flash_cs, sram_cs, sram_rw}, 0);
      chk("rs_outs", {busy, start, error, err_code, err_idx, checksum, words_done}, 0);
      chk("rs_addr", {flash_addr, sram_addr, sram_data_wr}, 0);
      step(); step();
      rst_in = 1'b0;
      step();
      s_req++;
      step(); step();
      chk("rs_late_done", {busy, start, error, sram_cs, flash_cs}, 0);
      chk("rs_late_words", {words_done, checksum}, 0);
      nf0 = nf;
      do_boot(16'd2);
      wait_end(500, ok);
      chk("rs_end", ok, 1);
      chk("rs_flags", {start, error, busy}, 3'b100);
      chk("rs_words", words_done, 16'd2);
      chk("rs_checksum", checksum, 32'h33333333);
      chk("rs_faddr0", flog[nf0], 25'h1FFFFFE);
      chk("rs_faddr1", flog[nf0 + 1], 25'h1FFFFFF);
      chk("rs_sram1", smem[17], 32'h22222222);

      chk("gap_violations", n_gapviol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
